// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_size_t  : access size encoding carried on req_size
//   dmem_state_t : responder FSM states
//   dmem_req_t   : latched request fields
//   dmem_err()   : error flag from size, byte address and array depth
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } dmem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    dmem_size_t  size;
    logic        uns;
  } dmem_req_t;

  // Illegal size, misalignment for the access width, or word index past the array.
  function automatic logic dmem_err(input dmem_size_t size, input logic [31:0] addr,
                                    input int unsigned depth);
    logic oor;
    oor = ({2'b00, addr[31:2]} >= depth);
    return (size == SZ_ILLEGAL) ||
           (size == SZ_HALF && addr[0]) ||
           (size == SZ_WORD && addr[1:0] != 2'b00) ||
           oor;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response bundle.
//   req_*  : request channel (valid/ready), driven by the core
//   rsp_*  : response channel (valid/ready), driven by the responder
//   master : core side, slave : responder side
interface dmem_responder_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  dmem_size_t  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit word (combinational).
//   addr_i     : byte offset within the word
//   size_i     : access size
//   wdata_i    : right-aligned store data
//   rword_i    : current array word
//   unsigned_i : zero-extend sub-word loads
//   wword_o    : store data replicated onto the target lanes
//   be_o       : per-byte write enable
//   rdata_o    : extracted and extended load data
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  dmem_size_t  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic        unsigned_i,
  output logic [31:0] wword_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    wword_o = '0;
    be_o    = '0;
    rdata_o = '0;
    rbyte   = rword_i[{addr_i, 3'b000} +: 8];
    rhalf   = rword_i[{addr_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: begin
        // Replicate so whichever lane is enabled sees the byte.
        wword_o = {4{wdata_i[7:0]}};
        be_o    = 4'b0001 << addr_i;
        rdata_o = {{24{~unsigned_i & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        wword_o = {2{wdata_i[15:0]}};
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        rdata_o = {{16{~unsigned_i & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        wword_o = wdata_i;
        be_o    = 4'b1111;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Stalling data-memory responder: one load/store in flight, response after
// WAIT_STATES extra cycles.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : request/response channels (slave side)
// The array is not reset. INIT_FILE names an optional preload image for the
// implementation flow; with none the contents start undefined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, cur;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] wword, ld_data, rword;
  logic [3:0]  be;
  logic [AW-1:0] widx;
  logic        err, accept, commit;

  // With zero wait states the commit edge is the accept edge, so the live bus
  // fields must be used while IDLE; afterwards the latched copy is used.
  always_comb begin
    cur = req_q;
    if (state_q == ST_IDLE)
      cur = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata,
              size: bus.req_size, uns: bus.req_unsigned};
  end

  assign err   = dmem_err(cur.size, cur.addr, DEPTH_WORDS);
  assign widx  = cur.addr[AW+1:2];
  assign rword = mem_q[widx];

  dmem_lane_align u_align (
    .addr_i     (cur.addr[1:0]),
    .size_i     (cur.size),
    .wdata_i    (cur.wdata),
    .rword_i    (rword),
    .unsigned_i (cur.uns),
    .wword_o    (wword),
    .be_o       (be),
    .rdata_o    (ld_data)
  );

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        if (WAIT_STATES == 0) state_d = ST_RESP;
        else begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= cur;
      if (commit) begin
        err_q   <= err;
        rdata_q <= (err || cur.write) ? 32'h0 : ld_data;
      end else if (state_q == ST_RESP && bus.rsp_ready) begin
        err_q   <= 1'b0;  // rdata deliberately keeps its last value
      end
    end
  end

  // Array write on the commit edge only; reset held across an edge suppresses it.
  always_ff @(posedge clk) begin
    if (commit && !reset && cur.write && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[widx][8*b +: 8] <= wword[8*b +: 8];
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_responder_if b1();
  dmem_responder_if b0();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .bus(b0));

  // Shared stimulus; sel0 routes valid/ready to the zero-wait instance.
  logic        sel0 = 1'b0;
  logic        t_valid = 1'b0, t_write = 1'b0, t_uns = 1'b0, t_rready = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  dmem_size_t  t_size = SZ_WORD;

  assign b1.req_valid    = t_valid & ~sel0;
  assign b0.req_valid    = t_valid & sel0;
  assign b1.rsp_ready    = t_rready & ~sel0;
  assign b0.rsp_ready    = t_rready & sel0;
  assign b1.req_write    = t_write;   assign b0.req_write    = t_write;
  assign b1.req_addr     = t_addr;    assign b0.req_addr     = t_addr;
  assign b1.req_wdata    = t_wdata;   assign b0.req_wdata    = t_wdata;
  assign b1.req_size     = t_size;    assign b0.req_size     = t_size;
  assign b1.req_unsigned = t_uns;     assign b0.req_unsigned = t_uns;

  logic        m_rvalid, m_err, m_qready;
  logic [31:0] m_rdata;
  assign m_rvalid = sel0 ? b0.rsp_valid : b1.rsp_valid;
  assign m_err    = sel0 ? b0.rsp_error : b1.rsp_error;
  assign m_qready = sel0 ? b0.req_ready : b1.req_ready;
  assign m_rdata  = sel0 ? b0.rsp_rdata : b1.rsp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input dmem_size_t s, input logic u);
    t_valid = 1'b1; t_write = w; t_addr = a; t_wdata = d; t_size = s; t_uns = u;
  endtask

  // One transaction; lat counts edges from the start of the accept cycle.
  task automatic op(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                    input dmem_size_t s, input logic u, input logic [31:0] exp_rd,
                    input logic exp_er, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    drive(w, a, d, s, u);
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      t_valid = 1'b0;
    end while (!m_rvalid && lat < 20);
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, m_rdata, exp_rd);
    chk({tag, " err"}, {31'b0, m_err}, {31'b0, exp_er});
    t_rready = 1'b1;
    @(posedge clk); #1;
    t_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst req_ready", {31'b0, m_qready}, 32'd1);
    chk("rst rsp_valid", {31'b0, m_rvalid}, 32'd0);
    chk("rst rdata", m_rdata, 32'h0);
    chk("rst err", {31'b0, m_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Basic word path and byte/half placement
    op("sw 10",   1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 32'h0,        0, 2);
    op("lw 10",   0, 32'h10, 32'h0,        SZ_WORD, 0, 32'hDEADBEEF, 0, 2);
    op("sw 0",    1, 32'h0,  32'h55555555, SZ_WORD, 0, 32'h0,        0, 2);
    op("sb 11",   1, 32'h11, 32'h00000080, SZ_BYTE, 0, 32'h0,        0, 2);
    op("lb 11",   0, 32'h11, 32'h0,        SZ_BYTE, 0, 32'hFFFFFF80, 0, 2);
    op("lbu 11",  0, 32'h11, 32'h0,        SZ_BYTE, 1, 32'h00000080, 0, 2);
    op("lw sb",   0, 32'h10, 32'h0,        SZ_WORD, 0, 32'hDEAD80EF, 0, 2);
    op("sh 12",   1, 32'h12, 32'h00001234, SZ_HALF, 0, 32'h0,        0, 2);
    op("lh 12",   0, 32'h12, 32'h0,        SZ_HALF, 0, 32'h00001234, 0, 2);
    op("lw sh",   0, 32'h10, 32'h0,        SZ_WORD, 0, 32'h123480EF, 0, 2);
    op("lh 10",   0, 32'h10, 32'h0,        SZ_HALF, 0, 32'hFFFF80EF, 0, 2);
    op("lhu 10",  0, 32'h10, 32'h0,        SZ_HALF, 1, 32'h000080EF, 0, 2);

    // Error cases: no write, zero data
    op("lh 13",   0, 32'h13,  32'h0,        SZ_HALF,    0, 32'h0, 1, 2);
    op("sw 12",   1, 32'h12,  32'h0,        SZ_WORD,    0, 32'h0, 1, 2);
    op("lw 400",  0, 32'h400, 32'h0,        SZ_WORD,    0, 32'h0, 1, 2);
    op("sw 400",  1, 32'h400, 32'hCAFEF00D, SZ_WORD,    0, 32'h0, 1, 2);
    op("sz11 ld", 0, 32'h10,  32'h0,        SZ_ILLEGAL, 0, 32'h0, 1, 2);
    op("sz11 st", 1, 32'h10,  32'hFFFFFFFF, SZ_ILLEGAL, 0, 32'h0, 1, 2);
    op("lw unch", 0, 32'h10,  32'h0,        SZ_WORD,    0, 32'h123480EF, 0, 2);
    op("lw 0",    0, 32'h0,   32'h0,        SZ_WORD,    0, 32'h55555555, 0, 2);
    op("sw 3fc",  1, 32'h3FC, 32'h0BADF00D, SZ_WORD,    0, 32'h0, 0, 2);
    op("lw 3fc",  0, 32'h3FC, 32'h0,        SZ_WORD,    0, 32'h0BADF00D, 0, 2);

    // Back-pressure on the response; a request pulse during RESP is ignored
    @(posedge clk); #1;
    drive(0, 32'h10, 32'h0, SZ_WORD, 0);
    @(posedge clk); #1; t_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold enter", {31'b0, m_rvalid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1, 32'h10, 32'h0, SZ_WORD, 0);
      else        t_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold valid", {31'b0, m_rvalid}, 32'd1);
      chk("hold rdata", m_rdata, 32'h123480EF);
      chk("hold req_ready", {31'b0, m_qready}, 32'd0);
    end
    t_valid = 1'b0; t_rready = 1'b1;
    @(posedge clk); #1; t_rready = 1'b0;
    chk("post hs ready", {31'b0, m_qready}, 32'd1);
    chk("post hs rdata kept", m_rdata, 32'h123480EF);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no stray rsp", {31'b0, m_rvalid}, 32'd0);
    end
    op("lw after hold", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'h123480EF, 0, 2);

    // Reset while a store is waiting to commit
    op("sw 20",   1, 32'h20, 32'h11223344, SZ_WORD, 0, 32'h0,        0, 2);
    op("lw 20",   0, 32'h20, 32'h0,        SZ_WORD, 0, 32'h11223344, 0, 2);
    @(posedge clk); #1;
    drive(1, 32'h20, 32'hAAAAAAAA, SZ_WORD, 0);
    @(posedge clk); #1; t_valid = 1'b0;
    chk("in wait ready", {31'b0, m_qready}, 32'd0);
    reset = 1'b1; #1;
    chk("mid rst ready", {31'b0, m_qready}, 32'd1);
    chk("mid rst valid", {31'b0, m_rvalid}, 32'd0);
    chk("mid rst rdata", m_rdata, 32'h0);
    chk("mid rst err", {31'b0, m_err}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    op("lw 20 kept", 0, 32'h20, 32'h0, SZ_WORD, 0, 32'h11223344, 0, 2);

    // Zero wait states
    sel0 = 1'b1;
    op("ws0 sw",  1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 32'h0,        0, 1);
    op("ws0 lw",  0, 32'h10, 32'h0,        SZ_WORD, 0, 32'hDEADBEEF, 0, 1);
    op("ws0 sb",  1, 32'h11, 32'h00000080, SZ_BYTE, 0, 32'h0,        0, 1);
    op("ws0 lb",  0, 32'h11, 32'h0,        SZ_BYTE, 0, 32'hFFFFFF80, 0, 1);
    op("ws0 err", 0, 32'h13, 32'h0,        SZ_HALF, 0, 32'h0,        1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
